// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, parity selectors
// and serial line levels.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..limit-1 while enabled, flags the terminal
// count and wraps to 0 on it. clr forces the count back to 0 and wins over
// en. limit must be at least 1. Shared with the receive-side edge counter.
`timescale 1ns/1ps
module uart_tx_bit_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_r;

  assign tc = (cnt_r == (limit - WIDTH'(1)));

  // Period counter: cleared on request, wraps to 0 at the terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (en) begin
      if (tc) begin
        cnt_r <= {WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + WIDTH'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser: start bit, DATA_WIDTH data bits LSB first,
// optional parity, stop bit. Every bit lasts the latched prescale value in
// clocks (0 is taken as 1). All frame settings are captured on acceptance.
// Optional build macro UART_TX_STOP2_EN adds a stop2 input selecting a
// second stop bit.
`timescale 1ns/1ps
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
`ifdef UART_TX_STOP2_EN
  input  logic                  stop2,
`endif
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  // Parity over the held data; odd parity inverts the XOR reduction.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic typ);
    calc_parity = (^d) ^ (typ == PAR_ODD);
  endfunction

  tx_state_t             state_r, state_next_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic [IDX_W-1:0]      idx_r, idx_next_s;
  logic                  tx_r, tx_next_s;
  logic                  busy_r, busy_next_s;
  logic                  done_r, done_next_s;
  logic                  accept_s;
  logic                  tc_s;
  logic                  stop2_sel_s;

`ifdef UART_TX_STOP2_EN
  logic stop2_r;

  // Captures the stop-bit count for the frame being accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stop2_r <= 1'b0;
    end else if (accept_s) begin
      stop2_r <= stop2;
    end else begin
      stop2_r <= stop2_r;
    end
  end

  assign stop2_sel_s = stop2_r;
`else
  assign stop2_sel_s = 1'b0;
`endif

  uart_tx_bit_timer #(
    .WIDTH (PRESCALE_W)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_r == IDLE),
    .en    (state_r != IDLE),
    .limit (prescale_r),
    .tc    (tc_s)
  );

  // Holding registers: frame settings frozen at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r     <= {DATA_WIDTH{1'b0}};
      prescale_r <= {PRESCALE_W{1'b0}};
      par_en_r   <= 1'b0;
      par_typ_r  <= PAR_EVEN;
    end else if (accept_s) begin
      data_r     <= p_data;
      prescale_r <= (prescale == {PRESCALE_W{1'b0}}) ? PRESCALE_W'(1) : prescale;
      par_en_r   <= par_en;
      par_typ_r  <= par_typ;
    end else begin
      data_r     <= data_r;
      prescale_r <= prescale_r;
      par_en_r   <= par_en_r;
      par_typ_r  <= par_typ_r;
    end
  end

  // Next-state, bit index and handshake decode.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    busy_next_s  = busy_r;
    done_next_s  = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_valid) begin
          accept_s     = 1'b1;
          state_next_s = START;
          idx_next_s   = {IDX_W{1'b0}};
          busy_next_s  = 1'b1;
        end else begin
          busy_next_s  = 1'b0;
        end
      end
      START: begin
        if (tc_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (tc_s) begin
          if (idx_r == IDX_LAST) begin
            state_next_s = par_en_r ? PARITY : STOP;
          end else begin
            idx_next_s   = idx_r + IDX_W'(1);
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (tc_s) begin
          state_next_s = STOP;
        end else begin
          state_next_s = PARITY;
        end
      end
      STOP: begin
        if (tc_s) begin
          if (stop2_sel_s) begin
            state_next_s = STOP2;
          end else begin
            state_next_s = IDLE;
            busy_next_s  = 1'b0;
            done_next_s  = 1'b1;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      STOP2: begin
        if (tc_s) begin
          state_next_s = IDLE;
          busy_next_s  = 1'b0;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = STOP2;
        end
      end
      default: begin
        state_next_s = IDLE;
        idx_next_s   = {IDX_W{1'b0}};
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Line level for the upcoming cycle, taken from the state being entered.
  always_comb begin
    tx_next_s = LINE_IDLE;
    case (state_next_s)
      IDLE:    tx_next_s = LINE_IDLE;
      START:   tx_next_s = START_BIT;
      DATA:    tx_next_s = data_r[idx_next_s];
      PARITY:  tx_next_s = calc_parity(data_r, par_typ_r);
      STOP:    tx_next_s = LINE_IDLE;
      STOP2:   tx_next_s = LINE_IDLE;
      default: tx_next_s = LINE_IDLE;
    endcase
  end

  // State and output flops; reset parks the line high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      tx_r    <= LINE_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      tx_r    <= tx_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  assign tx_out     = tx_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: plain, parity, prescale=0,
// back-to-back, busy collision, mid-frame reset and (with
// UART_TX_STOP2_EN) two stop bits.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic [7:0] prescale;
  logic       par_en;
  logic       par_typ;
`ifdef UART_TX_STOP2_EN
  logic       stop2;
`endif
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int vec_cnt;
  int err_cnt;

  uart_tx_serializer #(
    .DATA_WIDTH (8),
    .PRESCALE_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
`ifdef UART_TX_STOP2_EN
    .stop2      (stop2),
`endif
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a request at a falling edge; the next rising edge accepts it.
  task automatic start_frame(input logic [7:0] d, input logic [7:0] ps,
                             input logic pen, input logic ptyp, input logic hold);
    p_data     = d;
    prescale   = ps;
    par_en     = pen;
    par_typ    = ptyp;
    data_valid = 1'b1;
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
  endtask

  // Starts at the first cycle after acceptance; ends on the first idle cycle.
  task automatic check_frame(input string tag, input logic [7:0] d, input int ps,
                             input logic pen, input logic exp_par, input int nstop);
    int   nbits;
    int   hi;
    int   busy_cnt;
    int   done_cnt;
    logic exp_bit;
    nbits    = 9 + (pen ? 1 : 0) + nstop;
    busy_cnt = 0;
    done_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)               exp_bit = 1'b0;
      else if (b <= 8)          exp_bit = d[b-1];
      else if (pen && (b == 9)) exp_bit = exp_par;
      else                      exp_bit = 1'b1;
      hi = 0;
      for (int c = 0; c < ps; c++) begin
        hi       += (tx_out === 1'b1) ? 1 : 0;
        busy_cnt += (busy === 1'b1) ? 1 : 0;
        done_cnt += (frame_done === 1'b1) ? 1 : 0;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d high-cycles", tag, b), hi, exp_bit ? ps : 0);
    end
    check($sformatf("%s busy-length", tag), busy_cnt, ps * nbits);
    check($sformatf("%s done-in-frame", tag), done_cnt, 0);
    check($sformatf("%s end busy", tag), busy, 1'b0);
    check($sformatf("%s end frame_done", tag), frame_done, 1'b1);
    check($sformatf("%s end tx", tag), tx_out, 1'b1);
  endtask

  // Line must stay idle for n cycles with no request pending.
  task automatic idle_check(input string tag, input int n);
    int hi;
    int bz;
    int dn;
    hi = 0; bz = 0; dn = 0;
    for (int c = 0; c < n; c++) begin
      hi += (tx_out === 1'b1) ? 1 : 0;
      bz += (busy === 1'b1) ? 1 : 0;
      dn += (frame_done === 1'b1) ? 1 : 0;
      @(negedge clk);
    end
    check($sformatf("%s idle tx", tag), hi, n);
    check($sformatf("%s idle busy", tag), bz, 0);
    check($sformatf("%s idle done", tag), dn, 0);
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst        = 1'b0;
    p_data     = 8'h00;
    data_valid = 1'b0;
    prescale   = 8'd8;
    par_en     = 1'b0;
    par_typ    = 1'b0;
`ifdef UART_TX_STOP2_EN
    stop2      = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("reset tx", tx_out, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", frame_done, 1'b0);
    rst = 1'b1;
    idle_check("post-reset", 4);

    // Plain frame 0xA5, prescale 8: 0,1,0,1,0,0,1,0,1,1 -> 80 cycles
    start_frame(8'hA5, 8'd8, 1'b0, 1'b0, 1'b0);
    check_frame("plain", 8'hA5, 8, 1'b0, 1'b0, 1);
    @(negedge clk);
    check("plain done pulse width", frame_done, 1'b0);
    idle_check("plain", 8);

    // Even parity on 0xA5 (four ones) -> parity 0, 176 cycles
    start_frame(8'hA5, 8'd16, 1'b1, 1'b0, 1'b0);
    check_frame("par-even", 8'hA5, 16, 1'b1, 1'b0, 1);
    @(negedge clk);
    // Odd parity on 0xA5 -> parity 1
    start_frame(8'hA5, 8'd16, 1'b1, 1'b1, 1'b0);
    check_frame("par-odd", 8'hA5, 16, 1'b1, 1'b1, 1);
    @(negedge clk);
    // Odd parity on 0x07 (three ones) -> parity 0
    start_frame(8'h07, 8'd2, 1'b1, 1'b1, 1'b0);
    check_frame("par-odd-07", 8'h07, 2, 1'b1, 1'b0, 1);
    @(negedge clk);

    // prescale 0 behaves as 1 clock per bit
    start_frame(8'h5A, 8'd0, 1'b0, 1'b0, 1'b0);
    check_frame("ps0", 8'h5A, 1, 1'b0, 1'b0, 1);
    @(negedge clk);
    idle_check("ps0", 3);

    // Back-to-back with data_valid held: exactly one idle cycle between frames
    start_frame(8'h00, 8'd4, 1'b0, 1'b0, 1'b1);
    p_data = 8'hFF;
    check_frame("b2b-00", 8'h00, 4, 1'b0, 1'b0, 1);
    @(negedge clk);
    data_valid = 1'b0;
    check_frame("b2b-FF", 8'hFF, 4, 1'b0, 1'b0, 1);
    @(negedge clk);
    idle_check("b2b", 12);

    // Busy collision: 0x3C requested mid-frame of 0x81 is dropped
    start_frame(8'h81, 8'd8, 1'b0, 1'b0, 1'b0);
    fork
      check_frame("collide", 8'h81, 8, 1'b0, 1'b0, 1);
      begin
        repeat (20) @(negedge clk);
        p_data     = 8'h3C;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
      end
    join
    @(negedge clk);
    idle_check("collide", 20);

    // Reset during data bit 3 (cycles 32..39, level 0 for 0xA5)
    start_frame(8'hA5, 8'd8, 1'b0, 1'b0, 1'b0);
    repeat (34) @(negedge clk);
    check("pre-reset tx bit3", tx_out, 1'b0);
    check("pre-reset busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async reset tx", tx_out, 1'b1);
    check("async reset busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle_check("after reset", 30);
    start_frame(8'h3C, 8'd3, 1'b0, 1'b0, 1'b0);
    check_frame("recover", 8'h3C, 3, 1'b0, 1'b0, 1);
    @(negedge clk);

`ifdef UART_TX_STOP2_EN
    // Two stop bits: stop level 16 cycles, frame 88 cycles instead of 80
    stop2 = 1'b1;
    start_frame(8'hA5, 8'd8, 1'b0, 1'b0, 1'b0);
    stop2 = 1'b0;
    check_frame("stop2", 8'hA5, 8, 1'b0, 1'b0, 2);
    @(negedge clk);
    start_frame(8'hA5, 8'd8, 1'b0, 1'b0, 1'b0);
    check_frame("stop1", 8'hA5, 8, 1'b0, 1'b0, 1);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
